// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// 32 lines x 4 16-bit words. Tag = Addr[15:8], index = Addr[7:3], word = Addr[2:1].
// A miss on a dirty line writes back four words, then fills four words, one
// backing-memory handshake per word.
module cache_ctrl #(
  parameter int CACHE_ID = 0,     // 0 = instruction cache, 1 = data cache
  parameter bit WRITABLE = 1'b1   // 0 rejects every write request
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheReq,
  output logic        CacheHit,
  output logic        Err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  if (CACHE_ID != 0 && CACHE_ID != 1) begin : g_bad_cache_id
    $error("cache_ctrl: CACHE_ID must be 0 or 1");
  end

  // Encoding puts the beat number in bits [1:0] of the WB and FILL states, and
  // makes WB3+1 = FILL0 and FILL3+1 = DONE so every beat advances by increment.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    COMPARE = 4'd1,
    WB0     = 4'd4,
    WB1     = 4'd5,
    WB2     = 4'd6,
    WB3     = 4'd7,
    FILL0   = 4'd8,
    FILL1   = 4'd9,
    FILL2   = 4'd10,
    FILL3   = 4'd11,
    DONE    = 4'd12
  } state_e;

  state_e      state_q, state_d;

  // Latched request
  logic [15:1] addr_q;
  logic [15:0] din_q;
  logic        is_wr_q;
  logic [15:0] dout_q;

  // Line status and storage
  logic [31:0] valid_q;
  logic [31:0] dirty_q;
  logic [7:0]  tag_mem  [32];
  logic [15:0] data_mem [128];

  // Decoded request fields and per-state strobes
  logic [4:0]  idx;
  logic [1:0]  word;
  logic [7:0]  tag_in;
  logic [7:0]  old_tag;
  logic [1:0]  beat;
  logic        line_hit;
  logic [15:0] rd_word;
  logic        req_err;
  logic        req_ok;
  logic        accept;
  logic        complete;
  logic        fill_we;

  assign idx      = addr_q[7:3];
  assign word     = addr_q[2:1];
  assign tag_in   = addr_q[15:8];
  assign old_tag  = tag_mem[idx];
  assign beat     = state_q[1:0];
  assign line_hit = valid_q[idx] && (old_tag == tag_in);
  assign rd_word  = data_mem[{idx, word}];

  assign req_err  = (Rd && Wr) || (Addr[0] && (Rd || Wr)) || (Wr && !WRITABLE);
  assign req_ok   = (Rd || Wr) && !req_err;

  assign Stall    = (state_q != IDLE);

  // Read data is presented combinationally on the completion cycle and held afterwards.
  assign DataOut  = (complete && !is_wr_q) ? rd_word : dout_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and all FSM-driven outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    Done      = 1'b0;
    CacheHit  = 1'b0;
    CacheReq  = 1'b0;
    Err       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    accept    = 1'b0;
    complete  = 1'b0;
    fill_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_err) begin
          Err = 1'b1;
        end else if (req_ok) begin
          CacheReq = 1'b1;
          accept   = 1'b1;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (line_hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          complete = 1'b1;
          state_d  = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = WB0;
        end else begin
          state_d = FILL0;
        end
      end
      WB0, WB1, WB2, WB3: begin
        mem_wr    = 1'b1;
        mem_addr  = {old_tag, idx, beat, 1'b0};
        mem_wdata = data_mem[{idx, beat}];
        if (mem_ack) state_d = state_e'(state_q + 4'd1);
      end
      FILL0, FILL1, FILL2, FILL3: begin
        mem_rd   = 1'b1;
        mem_addr = {tag_in, idx, beat, 1'b0};
        if (mem_ack) begin
          fill_we = 1'b1;
          state_d = state_e'(state_q + 4'd1);
        end
      end
      DONE: begin
        Done     = 1'b1;
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, line status bits and the held read value.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      din_q   <= '0;
      is_wr_q <= 1'b0;
      dout_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= Addr[15:1];
        din_q   <= DataIn;
        is_wr_q <= Wr;
      end
      if (fill_we && beat == 2'd3) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (complete) begin
        if (is_wr_q) dirty_q[idx] <= 1'b1;
        else         dout_q       <= rd_word;
      end
    end
  end

  // Tag and data storage: fills from memory and stores from the pipeline.
  // NOTE: the arrays are deliberately not reset; clearing the valid bits is
  // enough to make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{idx, beat}] <= mem_rdata;
      if (beat == 2'd3) tag_mem[idx] <= tag_in;
    end
    if (complete && is_wr_q) data_mem[{idx, word}] <= din_q;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios followed by random
// accesses, compared against a line-level cache model and a reference memory.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheReq, CacheHit, Err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;

  always #5 clk = ~clk;

  cache_ctrl #(.CACHE_ID(1), .WRITABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheReq(CacheReq),
    .CacheHit(CacheHit), .Err(Err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } bus_t;

  // Backing memory seen by the DUT, and the reference copy the model maintains.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  // Memory responder: either ack tied high, or ack on the (ack_wait+1)th cycle of each word.
  bit  tie_ack  = 1'b1;
  int  ack_wait = 0;
  int  wait_cnt = 0;
  int  wait_next = 0;
  assign mem_ack   = tie_ack ? 1'b1 : ((mem_rd || mem_wr) && (wait_cnt == ack_wait));
  assign mem_rdata = mem[mem_addr[15:1]];

  // Bus monitor: logs handshakes, checks request stability and rd/wr exclusion.
  bus_t        bus_q[$];
  int          prot_err = 0;
  bit          prev_pend = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_rd, prev_wr;

  always @(negedge clk) begin
    if (mem_rd === 1'b1 && mem_wr === 1'b1) prot_err++;
    if (prev_pend && !(mem_rd === prev_rd && mem_wr === prev_wr &&
                       mem_addr === prev_addr && mem_wdata === prev_wdata)) prot_err++;
    if (rst !== 1'b1 && (mem_rd === 1'b1 || mem_wr === 1'b1) && mem_ack === 1'b1) begin
      bus_q.push_back('{mem_wr, mem_addr, mem_wr ? mem_wdata : mem_rdata});
      if (mem_wr) mem[mem_addr[15:1]] = mem_wdata;
    end
    wait_next  = ((mem_rd === 1'b1 || mem_wr === 1'b1) && mem_ack !== 1'b1 && rst !== 1'b1)
                 ? wait_cnt + 1 : 0;
    prev_pend  = (mem_rd === 1'b1 || mem_wr === 1'b1) && mem_ack !== 1'b1 && rst !== 1'b1;
    prev_rd    = mem_rd;
    prev_wr    = mem_wr;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  always @(posedge clk) wait_cnt <= wait_next;

  // Reference cache model: one entry per line.
  bit          m_valid [32];
  bit          m_dirty [32];
  logic [7:0]  m_tag   [32];
  logic [15:0] m_data  [32][4];
  logic [15:0] last_read = 16'h0000;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    last_read = 16'h0000;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_done"},  Done,      1'b0);
    check({tag, "_stall"}, Stall,     1'b0);
    check({tag, "_hit"},   CacheHit,  1'b0);
    check({tag, "_req"},   CacheReq,  1'b0);
    check({tag, "_err"},   Err,       1'b0);
    check({tag, "_memrd"}, mem_rd,    1'b0);
    check({tag, "_memwr"}, mem_wr,    1'b0);
    check({tag, "_maddr"}, mem_addr,  16'h0000);
    check({tag, "_mwdat"}, mem_wdata, 16'h0000);
  endtask

  bus_t last_bus[$];

  // One accepted access: predict with the model, drive, time it, compare.
  task automatic access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output bit hit_o, output logic [15:0] dout_o);
    logic [4:0]  idx;
    logic [1:0]  w;
    logic [7:0]  tg;
    logic [15:0] ea;
    logic [15:0] exp_dout;
    bit          exp_hit;
    int          nwords;
    int          exp_lat;
    int          stall_bad;
    bus_t        exp_bus[$];

    idx = a[7:3]; w = a[2:1]; tg = a[15:8];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    nwords = 0;
    exp_dout = 16'h0000;
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) begin
          ea = {m_tag[idx], idx, 2'(k), 1'b0};
          exp_bus.push_back('{1'b1, ea, m_data[idx][k]});
          ref_mem[ea[15:1]] = m_data[idx][k];
          nwords++;
        end
      end
      for (int k = 0; k < 4; k++) begin
        ea = {tg, idx, 2'(k), 1'b0};
        exp_bus.push_back('{1'b0, ea, ref_mem[ea[15:1]]});
        m_data[idx][k] = ref_mem[ea[15:1]];
        nwords++;
      end
      m_tag[idx] = tg; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
    end
    exp_lat = exp_hit ? 1 : 2 + nwords * (tie_ack ? 1 : ack_wait + 1);
    if (is_wr) begin
      m_data[idx][w] = d; m_dirty[idx] = 1'b1;
    end else begin
      exp_dout = m_data[idx][w]; last_read = exp_dout;
    end

    bus_q.delete();
    prot_err = 0;
    @(negedge clk);
    Rd = !is_wr; Wr = is_wr; Addr = a; DataIn = d;
    #1;
    check("req_pulse", CacheReq, 1'b1);
    check("req_noerr", Err, 1'b0);

    lat = -1; hit_o = 1'b0; dout_o = 16'hxxxx; stall_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        lat = k; hit_o = CacheHit; dout_o = DataOut;
        if (Stall !== 1'b1) stall_bad++;
        Rd = 1'b0; Wr = 1'b0;
        break;
      end
      if (Stall !== 1'b1 || Err !== 1'b0 || CacheReq !== 1'b0) stall_bad++;
      // Requests while stalled must be ignored.
      Rd = 1'($urandom); Wr = 1'b0;
      Addr = 16'($urandom) & 16'hFFFE; DataIn = 16'($urandom);
    end
    Rd = 1'b0; Wr = 1'b0;

    check($sformatf("lat_%h", a), lat, exp_lat);
    check($sformatf("hit_%h", a), hit_o, exp_hit);
    check("stall_during_access", stall_bad, 0);
    if (!is_wr) check($sformatf("dout_%h", a), dout_o, exp_dout);

    @(negedge clk);
    check("post_done_low", Done, 1'b0);
    check("post_stall_low", Stall, 1'b0);
    check("dout_held", DataOut, last_read);

    check("bus_count", bus_q.size(), exp_bus.size());
    for (int i = 0; i < exp_bus.size() && i < bus_q.size(); i++) begin
      check($sformatf("bus%0d_wr", i),   bus_q[i].wr,   exp_bus[i].wr);
      check($sformatf("bus%0d_addr", i), bus_q[i].addr, exp_bus[i].addr);
      check($sformatf("bus%0d_data", i), bus_q[i].data, exp_bus[i].data);
    end
    check("bus_protocol", prot_err, 0);
    last_bus = bus_q;
  endtask

  // A request that must be rejected with a single Err pulse.
  task automatic err_req(input logic r, input logic wv, input logic [15:0] a);
    bus_q.delete();
    @(negedge clk);
    Rd = r; Wr = wv; Addr = a; DataIn = 16'($urandom);
    #1;
    check("err_pulse", Err, 1'b1);
    check("err_noreq", CacheReq, 1'b0);
    check("err_nostall", Stall, 1'b0);
    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0;
    #1;
    check("err_after_stall", Stall, 1'b0);
    check("err_after_err", Err, 1'b0);
    check("err_no_bus", bus_q.size(), 0);
  endtask

  int          lat;
  bit          hit;
  logic [15:0] dout;
  logic [15:0] v;

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      mem[i] = v; ref_mem[i] = v;
    end
    for (int k = 0; k < 4; k++) begin
      mem[(16'h1230 >> 1) + k] = 16'hAAA0 + 16'(k); ref_mem[(16'h1230 >> 1) + k] = 16'hAAA0 + 16'(k);
      mem[(16'h2230 >> 1) + k] = 16'h2220 + 16'(k); ref_mem[(16'h2230 >> 1) + k] = 16'h2220 + 16'(k);
    end
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet_outputs("rst");
    check("rst_dout", DataOut, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check_quiet_outputs("idle");

    // Cold read: four fills, Done at N+6.
    access(1'b0, 16'h1234, 16'h0000, lat, hit, dout);
    check("cold_lat", lat, 6);
    check("cold_hit", hit, 1'b0);
    check("cold_dout", dout, 16'hAAA2);

    // Repeat read hits at N+1 with no traffic.
    access(1'b0, 16'h1234, 16'h0000, lat, hit, dout);
    check("warm_lat", lat, 1);
    check("warm_hit", hit, 1'b1);
    check("warm_dout", dout, 16'hAAA2);
    check("warm_nobus", last_bus.size(), 0);

    // Write hit dirties the line; conflicting read forces writeback then fill.
    access(1'b1, 16'h1234, 16'hBEEF, lat, hit, dout);
    check("wr_hit", hit, 1'b1);
    access(1'b0, 16'h2234, 16'h0000, lat, hit, dout);
    check("evict_lat", lat, 10);
    check("evict_dout", dout, 16'h2222);
    if (last_bus.size() == 8) begin
      check("evict_wb2_addr", last_bus[2].addr, 16'h1234);
      check("evict_wb2_data", last_bus[2].data, 16'hBEEF);
      check("evict_fill0_addr", last_bus[4].addr, 16'h2230);
      check("evict_fill0_rd", last_bus[4].wr, 1'b0);
    end

    // Rejected requests.
    err_req(1'b1, 1'b0, 16'h0011);
    err_req(1'b1, 1'b1, 16'h1234);
    err_req(1'b0, 1'b1, 16'h1235);

    // Slow memory: three cycles per word, Done at N+14.
    tie_ack = 1'b0; ack_wait = 2;
    access(1'b0, 16'h3000, 16'h0000, lat, hit, dout);
    check("slow_lat", lat, 14);
    tie_ack = 1'b1;

    // Reset during FILL2 abandons the fill.
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h5678;
    @(negedge clk); Rd = 1'b0;
    repeat (3) @(negedge clk);
    check("fill2_rd", mem_rd, 1'b1);
    check("fill2_addr", mem_addr, 16'h567C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet_outputs("midrst");
    check("midrst_dout", DataOut, 16'h0000);
    model_reset();
    access(1'b0, 16'h5678, 16'h0000, lat, hit, dout);
    check("midrst_remiss", hit, 1'b0);
    check("midrst_lat", lat, 6);

    // Random traffic over a few conflicting tags and indices.
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      a = {8'h40 + 8'($urandom_range(0, 2)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'b0};
      tie_ack  = 1'($urandom_range(0, 1));
      ack_wait = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) err_req(1'b1, 1'b0, a | 16'h0001);
      else access(1'($urandom_range(0, 1)), a, 16'($urandom), lat, hit, dout);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
